alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: four-phase sequencer (IDLE -> LOAD -> EXEC -> WB) that moves
// operands from a small register bank to an external combinational ALU,
// captures the result and writes it back.
// A host port can load the register bank at any time.
// Opcodes that are not recognised skip EXEC and finish with an error pulse.
`timescale 1ns/1ps
module alu_sequencer #(
  parameter int  ANCHO = 16,
  parameter int  NREG  = 8,
  localparam int AW    = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [3:0]       op_code_i,
  input  logic [AW-1:0]    op_srca_i,
  input  logic [AW-1:0]    op_srcb_i,
  input  logic [AW-1:0]    op_dst_i,
  input  logic             op_flag_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [ANCHO-1:0] wr_data_i,
  output logic [ANCHO-1:0] alu_a_o,
  output logic [ANCHO-1:0] alu_b_o,
  output logic             alu_flag_o,
  output logic [3:0]       alu_ctrl_o,
  input  logic [ANCHO-1:0] alu_result_i,
  output logic             done_o,
  output logic             err_o,
  output logic [ANCHO-1:0] result_o
);

  localparam logic [3:0] OP_AND = 4'b1100;
  localparam logic [3:0] OP_OR  = 4'b1101;
  localparam logic [3:0] OP_ADD = 4'b1010;
  localparam logic [3:0] OP_SUB = 4'b1011;
  localparam logic [3:0] OP_SHL = 4'b1110;

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, WB} state_t;

  state_t           state;
  logic [3:0]       code;
  logic [AW-1:0]    srca;
  logic [AW-1:0]    srcb;
  logic [AW-1:0]    dst;
  logic             flag;
  logic [ANCHO-1:0] regbank [NREG];
  // Operand registers double as the ALU operand outputs; they are non-zero
  // only while EXEC is active.
  logic [ANCHO-1:0] opnd_a;
  logic [ANCHO-1:0] opnd_b;
  logic [3:0]       ctrl;
  logic             flag_out;
  logic [ANCHO-1:0] res;
  logic [ANCHO-1:0] result;
  logic             done;
  logic             err;

  function automatic logic is_legal(input logic [3:0] c);
    return c inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SHL};
  endfunction

  function automatic logic uses_carry(input logic [3:0] c);
    return (c == OP_ADD) || (c == OP_SUB);
  endfunction

  assign op_ready_o = (state == IDLE);
  assign alu_a_o    = opnd_a;
  assign alu_b_o    = opnd_b;
  assign alu_ctrl_o = ctrl;
  assign alu_flag_o = flag_out;
  assign done_o     = done;
  assign err_o      = err;
  assign result_o   = result;

  // Sequencer FSM, register bank and registered ALU/status outputs.
  // The write-back is assigned after the host write so it wins on a same-address collision.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      code     <= '0;
      srca     <= '0;
      srcb     <= '0;
      dst      <= '0;
      flag     <= 1'b0;
      opnd_a   <= '0;
      opnd_b   <= '0;
      ctrl     <= '0;
      flag_out <= 1'b0;
      res      <= '0;
      result   <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      for (int i = 0; i < NREG; i++) regbank[i] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (wr_en_i) regbank[wr_addr_i] <= wr_data_i;
      case (state)
        IDLE: begin
          if (op_valid_i) begin
            code  <= op_code_i;
            srca  <= op_srca_i;
            srcb  <= op_srcb_i;
            dst   <= op_dst_i;
            flag  <= op_flag_i;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (is_legal(code)) begin
            opnd_a   <= regbank[srca];
            opnd_b   <= regbank[srcb];
            ctrl     <= code;
            flag_out <= uses_carry(code) ? flag : 1'b0;
            state    <= EXEC;
          end else begin
            state <= WB;
          end
        end
        EXEC: begin
          res      <= alu_result_i;
          opnd_a   <= '0;
          opnd_b   <= '0;
          ctrl     <= '0;
          flag_out <= 1'b0;
          state    <= WB;
        end
        WB: begin
          if (is_legal(code)) begin
            regbank[dst] <= res;
            result       <= res;
          end
          done  <= 1'b1;
          err   <= ~is_legal(code);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
